// File: rtl/ihex_sram_loader.sv
// Intel-HEX ASCII loader: parses records and writes byte-swapped words to SRAM.
// Holds the core in reset until a valid EOF record has been parsed.
module ihex_sram_loader #(
  parameter int          ADDR_W   = 16,
  parameter logic [15:0] HI_MATCH = 16'h8010,
  parameter logic [17:0] HI_BASE  = 18'h20000
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              rx_valid_i,
  input  logic [7:0]        rx_data_i,
  output logic              rx_ready_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic              mem_gnt_i,
  output logic              core_rst_no,
  output logic              done_o,
  output logic              error_o,
  output logic [1:0]        err_code_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_ADDR, S_TYPE,
    S_DATA, S_CSUM, S_DONE, S_ERR
  } state_e;

  state_e            state_q, state_d;
  logic              run_q;
  logic              nib_q, nib_d;
  logic [3:0]        hi_q, hi_d;
  logic [7:0]        len_q, len_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [15:0]       addr_q, addr_d;
  logic [7:0]        type_q, type_d;
  logic [7:0]        sum_q, sum_d;
  logic [23:0]       dbuf_q, dbuf_d;
  logic [17:0]       base_q, base_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              crst_q, crst_d;
  logic [1:0]        err_q, err_d;

  logic       acc;
  logic       hex_v;
  logic [3:0] hex_n;
  logic       byte_v;
  logic [7:0] byte_b;
  logic       ty_ok;
  logic [17:0] bsum;

  assign acc  = rx_valid_i & rx_ready_o;
  assign bsum = base_q + {2'b00, addr_q};

  assign rx_ready_o  = run_q & ~req_q;
  assign mem_req_o   = req_q;
  assign mem_addr_o  = maddr_q;
  assign mem_wdata_o = wdata_q;
  assign core_rst_no = crst_q;
  assign done_o      = (state_q == S_DONE);
  assign error_o     = (state_q == S_ERR);
  assign err_code_o  = err_q;

  // ASCII hex digit decode, case-insensitive
  always_comb begin
    hex_v = 1'b1;
    hex_n = 4'h0;
    unique case (1'b1)
      (rx_data_i >= 8'h30 && rx_data_i <= 8'h39):
        hex_n = rx_data_i[3:0];
      (rx_data_i >= 8'h41 && rx_data_i <= 8'h46),
      (rx_data_i >= 8'h61 && rx_data_i <= 8'h66):
        hex_n = rx_data_i[3:0] + 4'd9;
      default:
        hex_v = 1'b0;
    endcase
  end

  // Record parser, word assembly and write handshake
  always_comb begin
    state_d = state_q;
    nib_d   = nib_q;
    hi_d    = hi_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    type_d  = type_q;
    sum_d   = sum_q;
    dbuf_d  = dbuf_q;
    base_d  = base_q;
    waddr_d = waddr_q;
    req_d   = req_q;
    maddr_d = maddr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    crst_d  = (state_q == S_DONE);
    byte_v  = 1'b0;
    byte_b  = {hi_q, hex_n};
    ty_ok   = 1'b0;

    if (req_q && mem_gnt_i) req_d = 1'b0;

    if (acc) begin
      unique case (state_q)
        S_IDLE: begin
          if (rx_data_i == 8'h3A) begin
            state_d = S_LEN;
            sum_d   = 8'h00;
            nib_d   = 1'b0;
            cnt_d   = 8'h00;
          end else if (rx_data_i != 8'h0D &&
                       rx_data_i != 8'h0A &&
                       rx_data_i != 8'h20) begin
            state_d = S_ERR;
            err_d   = 2'd1;
          end
        end
        S_LEN, S_ADDR, S_TYPE, S_DATA, S_CSUM: begin
          if (!hex_v) begin
            state_d = S_ERR;
            err_d   = 2'd1;
          end else if (!nib_q) begin
            nib_d = 1'b1;
            hi_d  = hex_n;
          end else begin
            nib_d  = 1'b0;
            byte_v = 1'b1;
          end
        end
        default: ;
      endcase
    end

    if (byte_v) begin
      sum_d = sum_q + byte_b;
      unique case (state_q)
        S_LEN: begin
          len_d   = byte_b;
          cnt_d   = 8'h00;
          state_d = S_ADDR;
        end
        S_ADDR: begin
          addr_d = {addr_q[7:0], byte_b};
          cnt_d  = cnt_q + 8'd1;
          if (cnt_q[0]) state_d = S_TYPE;
        end
        S_TYPE: begin
          type_d  = byte_b;
          cnt_d   = 8'h00;
          waddr_d = ADDR_W'(bsum >> 2);
          unique case (byte_b)
            8'h00: ty_ok = len_q inside {8'd4, 8'd8, 8'd12, 8'd16};
            8'h01: ty_ok = (len_q == 8'd0);
            8'h04: ty_ok = (len_q == 8'd2);
            8'h03, 8'h05: ty_ok = 1'b1;
            default: ty_ok = 1'b0;
          endcase
          if (!ty_ok) begin
            state_d = S_ERR;
            err_d   = 2'd2;
          end else if (len_q == 8'd0) begin
            state_d = S_CSUM;
          end else begin
            state_d = S_DATA;
          end
        end
        S_DATA: begin
          if (cnt_q[1:0] == 2'd3) begin
            if (type_q == 8'h00) begin
              req_d   = 1'b1;
              maddr_d = waddr_q;
              wdata_d = {byte_b, dbuf_q};
              waddr_d = waddr_q + ADDR_W'(1);
            end
          end else begin
            dbuf_d[8*cnt_q[1:0] +: 8] = byte_b;
          end
          cnt_d = cnt_q + 8'd1;
          if (cnt_d == len_q) state_d = S_CSUM;
        end
        S_CSUM: begin
          if (sum_d != 8'h00) begin
            state_d = S_ERR;
            err_d   = 2'd3;
          end else if (type_q == 8'h01) begin
            state_d = S_DONE;
          end else begin
            state_d = S_IDLE;
            if (type_q == 8'h04)
              base_d = ({dbuf_q[7:0], dbuf_q[15:8]} == HI_MATCH) ?
                       HI_BASE : 18'h0;
          end
        end
        default: ;
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      run_q   <= 1'b0;
      nib_q   <= 1'b0;
      hi_q    <= 4'h0;
      len_q   <= 8'h00;
      cnt_q   <= 8'h00;
      addr_q  <= 16'h0000;
      type_q  <= 8'h00;
      sum_q   <= 8'h00;
      dbuf_q  <= 24'h0;
      base_q  <= 18'h0;
      waddr_q <= '0;
      req_q   <= 1'b0;
      maddr_q <= '0;
      wdata_q <= 32'h0;
      crst_q  <= 1'b0;
      err_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
      nib_q   <= nib_d;
      hi_q    <= hi_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      type_q  <= type_d;
      sum_q   <= sum_d;
      dbuf_q  <= dbuf_d;
      base_q  <= base_d;
      waddr_q <= waddr_d;
      req_q   <= req_d;
      maddr_q <= maddr_d;
      wdata_q <= wdata_d;
      crst_q  <= crst_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_ihex_sram_loader.sv
// Bench for ihex_sram_loader: directed and random HEX images checked
// against a procedural Intel-HEX reference parser.
module tb_ihex_sram_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt = 1'b0;
  logic        core_rst_n;
  logic        done;
  logic        error;
  logic [1:0]  err_code;

  ihex_sram_loader dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .rx_valid_i (rx_valid),
    .rx_data_i  (rx_data),
    .rx_ready_o (rx_ready),
    .mem_req_o  (mem_req),
    .mem_addr_o (mem_addr),
    .mem_wdata_o(mem_wdata),
    .mem_gnt_i  (mem_gnt),
    .core_rst_no(core_rst_n),
    .done_o     (done),
    .error_o    (error),
    .err_code_o (err_code)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [47:0] got[$];
  logic [47:0] exp_q[$];
  bit m_done, m_err;
  int m_code;

  bit gnt_en = 1'b1;
  bit stall_mode = 1'b0;
  int stall_bad = 0;
  int unstable = 0;
  int stall_len = 0;
  int stall_max = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] req);
    checks++;
    if (obs !== req) begin
      errors++;
      $display("FAIL %s: got=%0h exp=%0h", tag, obs, req);
    end
  endtask

  // write capture, stall and stability monitor
  logic        p_req = 1'b0;
  logic [47:0] p_aw = '0;
  always @(posedge clk) begin
    if (rst_n) begin
      if (mem_req && mem_gnt) got.push_back({mem_addr, mem_wdata});
      if (mem_req && rx_ready) stall_bad++;
      if (mem_req && p_req && {mem_addr, mem_wdata} != p_aw) unstable++;
      if (mem_req && !mem_gnt) stall_len++;
      else stall_len = 0;
      if (stall_len > stall_max) stall_max = stall_len;
    end
    p_req = mem_req;
    p_aw  = {mem_addr, mem_wdata};
  end

  // grant driver: random latency, or fixed 5-cycle stall
  initial begin
    int dly;
    dly = 0;
    forever begin
      @(negedge clk);
      if (mem_req && gnt_en) begin
        if (dly == 0) mem_gnt = 1'b1;
        else begin
          dly--;
          mem_gnt = 1'b0;
        end
      end else begin
        mem_gnt = 1'b0;
        dly = stall_mode ? 5 : int'($urandom_range(0, 3));
      end
    end
  end

  function automatic int hexv(input byte c);
    if (c >= "0" && c <= "9") return c - "0";
    if (c >= "A" && c <= "F") return c - "A" + 10;
    if (c >= "a" && c <= "f") return c - "a" + 10;
    return -1;
  endfunction

  function automatic int rd_byte(input string s, inout int p);
    int h, l;
    if (p >= s.len()) return -1;
    h = hexv(s[p]);
    p++;
    if (h < 0) return -2;
    if (p >= s.len()) return -1;
    l = hexv(s[p]);
    p++;
    if (l < 0) return -2;
    return h * 16 + l;
  endfunction

  // reference Intel-HEX parser: expected writes and final status
  function automatic void model(input string s);
    int p, len, addr, typ, v, sum, base, cs, i;
    bit fail, ok;
    logic [15:0] wa;
    int d[16];
    exp_q.delete();
    m_done = 0; m_err = 0; m_code = 0;
    base = 0; p = 0;
    while (p < s.len() && !m_done && !m_err) begin
      byte c;
      c = s[p];
      p++;
      if (c == 8'h0D || c == 8'h0A || c == " ") continue;
      if (c != ":") begin m_err = 1; m_code = 1; break; end
      len = rd_byte(s, p);
      if (len == -2) begin m_err = 1; m_code = 1; end
      if (len < 0) break;
      v = rd_byte(s, p);
      if (v == -2) begin m_err = 1; m_code = 1; end
      if (v < 0) break;
      addr = v * 256;
      v = rd_byte(s, p);
      if (v == -2) begin m_err = 1; m_code = 1; end
      if (v < 0) break;
      addr += v;
      typ = rd_byte(s, p);
      if (typ == -2) begin m_err = 1; m_code = 1; end
      if (typ < 0) break;
      ok = (typ == 0 && (len == 4 || len == 8 || len == 12 || len == 16)) ||
           (typ == 1 && len == 0) || (typ == 4 && len == 2) ||
           typ == 3 || typ == 5;
      if (!ok) begin m_err = 1; m_code = 2; break; end
      sum = len + (addr >> 8) + (addr & 255) + typ;
      wa = 16'((base + addr) >> 2);
      fail = 0;
      for (i = 0; i < len; i++) begin
        v = rd_byte(s, p);
        if (v < 0) begin
          if (v == -2) begin m_err = 1; m_code = 1; end
          fail = 1;
          break;
        end
        sum += v;
        if (i < 16) d[i] = v;
        if (typ == 0 && i % 4 == 3)
          exp_q.push_back({wa + 16'(i / 4), 8'(d[i]), 8'(d[i-1]),
                           8'(d[i-2]), 8'(d[i-3])});
      end
      if (fail) break;
      cs = rd_byte(s, p);
      if (cs == -2) begin m_err = 1; m_code = 1; end
      if (cs < 0) break;
      if (((sum + cs) & 255) != 0) begin m_err = 1; m_code = 3; break; end
      if (typ == 1) m_done = 1;
      if (typ == 4) base = ((d[0] * 256 + d[1]) == 'h8010) ? 'h20000 : 0;
    end
  endfunction

  function automatic string mkrec(input int len, input int addr,
                                  input int typ, input logic [7:0] d[$],
                                  input int adj, input bit lower);
    string s;
    int sum;
    sum = len + (addr >> 8) + (addr & 255) + typ;
    s = $sformatf(":%02X%04X%02X", len, addr, typ);
    foreach (d[i]) begin
      s = {s, $sformatf("%02X", d[i])};
      sum += d[i];
    end
    s = {s, $sformatf("%02X", ((256 - (sum & 255)) + adj) & 255)};
    if (lower) s = s.tolower();
    return s;
  endfunction

  task automatic send_str(input string s);
    int n;
    @(negedge clk);
    for (int i = 0; i < s.len(); i++) begin
      rx_valid = 1'b1;
      rx_data  = s[i];
      n = 0;
      while (!rx_ready && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (n >= 200) begin
        chk("rx_timeout", 1, 0);
        rx_valid = 1'b0;
        return;
      end
      @(posedge clk);
      @(negedge clk);
    end
    rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_outs", {rx_ready, mem_req, mem_addr, mem_wdata, core_rst_n,
                     done, error, err_code}, 0);
    rst_n = 1'b1;
    #1;
    chk("rdy_rel", rx_ready, 0);
    @(negedge clk);
    chk("rdy_1cyc", rx_ready, 1);
  endtask

  task automatic run_image(input string tag, input string s);
    int k;
    got.delete();
    send_str(s);
    k = 0;
    while (mem_req && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_req_idle"}, mem_req, 0);
    repeat (3) @(negedge clk);
    model(s);
    chk({tag, "_nwr"}, got.size(), exp_q.size());
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      chk($sformatf("%s_wr%0d", tag, i), got[i], exp_q[i]);
    chk({tag, "_done"}, done, m_done);
    chk({tag, "_err"}, error, m_err);
    chk({tag, "_code"}, err_code, m_code);
    chk({tag, "_crst"}, core_rst_n, m_done);
  endtask

  initial begin
    logic [7:0] d[$];
    string s, eof;
    int k;
    eof = ":00000001FF";

    // 1: single word then EOF; done then core release one cycle later
    do_reset();
    got.delete();
    send_str(":0400000013000000E9\n:00000001FF");
    chk("t1_done", done, 1);
    chk("t1_crst0", core_rst_n, 0);
    @(negedge clk);
    chk("t1_crst1", core_rst_n, 1);
    chk("t1_nwr", got.size(), 1);
    chk("t1_word", got.size() > 0 ? got[0] : '0, {16'h0000, 32'h00000013});

    // 2: high base selected by type 04
    do_reset();
    d = '{8'h80, 8'h10};
    s = mkrec(2, 0, 4, d, 0, 0);
    d = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    s = {s, "\n", mkrec(4, 8, 0, d, 0, 0), "\n", eof};
    run_image("t2", s);
    chk("t2_word", got.size() > 0 ? got[0] : '0, {16'h8002, 32'hDDCCBBAA});

    // 3: 16-byte record with 5-cycle grant stalls
    do_reset();
    stall_mode = 1'b1;
    stall_max = 0;
    d.delete();
    for (int i = 0; i < 16; i++) d.push_back(8'($urandom));
    s = {mkrec(16, 'h0100, 0, d, 0, 0), "\n", eof};
    run_image("t3", s);
    chk("t3_stall5", stall_max, 5);
    stall_mode = 1'b0;

    // 4: bad checksum, later EOF ignored
    do_reset();
    d = '{8'h01, 8'h02, 8'h03, 8'h04};
    s = {mkrec(4, 'h0010, 0, d, 1, 0), "\n", eof};
    run_image("t4", s);
    chk("t4_code3", err_code, 3);

    // 5: bad length, bad char, CR/LF between records
    do_reset();
    run_image("t5a", ":03000000010203F9");
    chk("t5a_code2", err_code, 2);
    do_reset();
    run_image("t5b", ":04000000G0");
    chk("t5b_code1", err_code, 1);
    do_reset();
    d = '{8'h11, 8'h22, 8'h33, 8'h44};
    s = {mkrec(4, 0, 0, d, 0, 1), "\015\012 ", mkrec(4, 4, 0, d, 0, 0),
         "\015\012", eof};
    run_image("t5c", s);

    // 6: reset during second word of a 4-word record
    do_reset();
    got.delete();
    gnt_en = 1'b0;
    d.delete();
    for (int i = 0; i < 16; i++) d.push_back(8'(i + 1));
    s = mkrec(16, 'h0040, 0, d, 0, 0);
    send_str(s.substr(0, 16));
    gnt_en = 1'b1;
    k = 0;
    while (got.size() < 1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    gnt_en = 1'b0;
    send_str(s.substr(17, 24));
    chk("t6_req_pend", mem_req, 1);
    #2 rst_n = 1'b0;
    #1 chk("t6_req_async", mem_req, 0);
    gnt_en = 1'b1;
    do_reset();
    d = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    s = {mkrec(4, 'h0020, 0, d, 0, 0), "\n", eof};
    run_image("t6", s);

    // random images
    for (int t = 0; t < 8; t++) begin
      int nrec, len, adj;
      bit lower;
      do_reset();
      s = "";
      nrec = $urandom_range(2, 5);
      for (int r = 0; r < nrec; r++) begin
        lower = 1'($urandom);
        adj = ($urandom_range(0, 11) == 0) ? 1 : 0;
        if ($urandom_range(0, 3) == 0) begin
          d.delete();
          if ($urandom_range(0, 1) == 0) d = '{8'h80, 8'h10};
          else d = '{8'($urandom), 8'($urandom)};
          s = {s, mkrec(2, 0, 4, d, adj, lower), "\n"};
        end else begin
          len = 4 * $urandom_range(1, 4);
          d.delete();
          for (int i = 0; i < len; i++) d.push_back(8'($urandom));
          s = {s, mkrec(len, int'($urandom_range(0, 16'hFFFF)), 0, d, adj,
                        lower), ($urandom_range(0, 1) == 0) ? "\015\012" : "\n"};
        end
      end
      s = {s, eof};
      run_image($sformatf("rnd%0d", t), s);
    end

    chk("stall_rdy", stall_bad, 0);
    chk("stable_aw", unstable, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got=running exp=finished");
    $fatal(1);
  end

endmodule
